// File: rtl/cuckoo_pkg.sv
// Shared encodings and hash functions for the two-table cuckoo hash engine.
// Hash helpers take the key zero-extended to 64 bits, so KEY_W is limited to 64.
package cuckoo_pkg;

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'b00,
      OP_INSERT = 2'b01,
      OP_DELETE = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_INSERTED  = 3'd0,
      ST_FOUND     = 3'd1,
      ST_NOT_FOUND = 3'd2,
      ST_DUPLICATE = 3'd3,
      ST_EVICTED   = 3'd4,
      ST_DELETED   = 3'd5,
      ST_BAD_OP    = 3'd6
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROBE,
      S_KICK,
      S_RESP
   } state_e;

   localparam int KICKS_OUT_W = 4;

   function automatic logic [15:0] hash1(input logic [63:0] key, input int idx_w);
      logic [63:0] mask;
      mask = (64'd1 << idx_w) - 64'd1;
      return 16'(key & mask);
   endfunction

   function automatic logic [15:0] hash2(input logic [63:0] key, input int idx_w);
      logic [63:0] mask;
      logic [63:0] mid;
      logic [63:0] high;
      mask = (64'd1 << idx_w) - 64'd1;
      mid  = key >> idx_w;
      high = key >> (2 * idx_w);
      return 16'((mid ^ high) & mask);
   endfunction

endpackage

// File: rtl/cuckoo_hash_engine_table.sv
// One cuckoo table: valid bit plus key per entry, combinational read,
// synchronous write, single-entry invalidate and bulk clear.
module cuckoo_table
   import cuckoo_pkg::*;
#(
   parameter int KEY_W = 32,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [KEY_W-1:0] rd_key,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [KEY_W-1:0] wr_key,
   input  logic             inv_en,
   input  logic [IDX_W-1:0] inv_idx
);
   localparam int DEPTH = 2 ** IDX_W;

   logic [DEPTH-1:0] valid_reg;
   logic [KEY_W-1:0] key_mem [DEPTH];

   // Write is applied after invalidate so a same-cycle write to that slot wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
      end else if (clear) begin
         valid_reg <= '0;
      end else begin
         if (inv_en) valid_reg[inv_idx] <= 1'b0;
         if (wr_en)  valid_reg[wr_idx]  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) key_mem[wr_idx] <= wr_key;
   end

   assign rd_valid = valid_reg[rd_idx];
   assign rd_key   = key_mem[rd_idx];

endmodule

// File: rtl/cuckoo_hash_engine.sv
// Two-table cuckoo hash engine: lookup, insert with bounded kick-out chain,
// delete; valid/ready handshakes on request and response.
module cuckoo_hash_engine
   import cuckoo_pkg::*;
#(
   parameter int KEY_W     = 32,
   parameter int IDX_W     = 4,
   parameter int MAX_KICKS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [KEY_W-1:0] req_key,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [2:0]       resp_status,
   output logic [KEY_W-1:0] resp_key,
   output logic [3:0]       resp_kicks
);
   localparam int CNT_W = $clog2(MAX_KICKS + 1) + 1;

   state_e           state_reg;
   op_e              op_reg;
   logic [KEY_W-1:0] key_reg;
   logic [KEY_W-1:0] carry_reg;
   logic             target_reg;
   logic [CNT_W-1:0] kick_cnt_reg;

   logic [IDX_W-1:0] h_req   [2];
   logic [IDX_W-1:0] h_carry [2];
   logic [IDX_W-1:0] rd_idx  [2];
   logic             rd_valid[2];
   logic [KEY_W-1:0] rd_key  [2];
   logic             hit_side[2];
   logic             wr_en   [2];
   logic [IDX_W-1:0] wr_idx  [2];
   logic [KEY_W-1:0] wr_key  [2];
   logic             inv_en  [2];

   logic             hit;
   logic             occ_valid;
   logic [KEY_W-1:0] occ_key;
   logic             at_max;
   logic [3:0]       kicks_sat;
   logic             tbl_clear;

   assign h_req[0]   = IDX_W'(hash1(64'(key_reg), IDX_W));
   assign h_req[1]   = IDX_W'(hash2(64'(key_reg), IDX_W));
   assign h_carry[0] = IDX_W'(hash1(64'(carry_reg), IDX_W));
   assign h_carry[1] = IDX_W'(hash2(64'(carry_reg), IDX_W));

   assign tbl_clear = clear && (state_reg == S_IDLE);
   assign req_ready = (state_reg == S_IDLE) && !clear;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_table
         // While kicking, both ports follow the carried key; otherwise the request key.
         assign rd_idx[gi]   = (state_reg == S_KICK) ? h_carry[gi] : h_req[gi];
         assign hit_side[gi] = rd_valid[gi] && (rd_key[gi] == key_reg);

         cuckoo_table #(
            .KEY_W (KEY_W),
            .IDX_W (IDX_W)
         ) u_table (
            .clk      (clk),
            .rst      (rst),
            .clear    (tbl_clear),
            .rd_idx   (rd_idx[gi]),
            .rd_valid (rd_valid[gi]),
            .rd_key   (rd_key[gi]),
            .wr_en    (wr_en[gi]),
            .wr_idx   (wr_idx[gi]),
            .wr_key   (wr_key[gi]),
            .inv_en   (inv_en[gi]),
            .inv_idx  (h_req[gi])
         );
      end
   endgenerate

   assign hit       = hit_side[0] || hit_side[1];
   assign occ_valid = rd_valid[target_reg];
   assign occ_key   = rd_key[target_reg];
   assign at_max    = (kick_cnt_reg == CNT_W'(MAX_KICKS));
   assign kicks_sat = (32'(kick_cnt_reg) > 32'd15) ? 4'd15 : 4'(kick_cnt_reg);

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         wr_en[s]  = 1'b0;
         wr_idx[s] = h_req[s];
         wr_key[s] = key_reg;
         inv_en[s] = 1'b0;
      end
      case (state_reg)
         S_PROBE: begin
            if (op_reg == OP_INSERT && !hit) begin
               // With both slots full the new key still lands in T1 and evicts its occupant.
               if (rd_valid[0] && !rd_valid[1]) wr_en[1] = 1'b1;
               else                             wr_en[0] = 1'b1;
            end else if (op_reg == OP_DELETE) begin
               inv_en[0] = hit_side[0];
               inv_en[1] = hit_side[1];
            end
         end
         S_KICK: begin
            if (!occ_valid || !at_max) begin
               wr_en[target_reg]  = 1'b1;
               wr_idx[target_reg] = h_carry[target_reg];
               wr_key[target_reg] = carry_reg;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         op_reg       <= OP_LOOKUP;
         key_reg      <= '0;
         carry_reg    <= '0;
         target_reg   <= 1'b0;
         kick_cnt_reg <= '0;
         resp_valid   <= 1'b0;
         resp_status  <= ST_INSERTED;
         resp_key     <= '0;
         resp_kicks   <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  key_reg   <= req_key;
                  op_reg    <= op_e'(req_op);
                  state_reg <= S_PROBE;
               end
            end
            S_PROBE: begin
               resp_key   <= key_reg;
               resp_kicks <= '0;
               resp_valid <= 1'b1;
               state_reg  <= S_RESP;
               case (op_reg)
                  OP_LOOKUP: resp_status <= hit ? ST_FOUND : ST_NOT_FOUND;
                  OP_DELETE: resp_status <= hit ? ST_DELETED : ST_NOT_FOUND;
                  OP_INSERT: begin
                     if (hit) begin
                        resp_status <= ST_DUPLICATE;
                     end else if (!rd_valid[0] || !rd_valid[1]) begin
                        resp_status <= ST_INSERTED;
                     end else begin
                        carry_reg    <= rd_key[0];
                        target_reg   <= 1'b1;
                        kick_cnt_reg <= CNT_W'(1);
                        resp_valid   <= 1'b0;
                        state_reg    <= S_KICK;
                     end
                  end
                  default: resp_status <= ST_BAD_OP;
               endcase
            end
            S_KICK: begin
               if (!occ_valid) begin
                  resp_status <= ST_INSERTED;
                  resp_key    <= key_reg;
                  resp_kicks  <= kicks_sat;
                  resp_valid  <= 1'b1;
                  state_reg   <= S_RESP;
               end else if (at_max) begin
                  resp_status <= ST_EVICTED;
                  resp_key    <= carry_reg;
                  resp_kicks  <= kicks_sat;
                  resp_valid  <= 1'b1;
                  state_reg   <= S_RESP;
               end else begin
                  carry_reg    <= occ_key;
                  target_reg   <= ~target_reg;
                  kick_cnt_reg <= kick_cnt_reg + CNT_W'(1);
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state_reg  <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule
